// File: rtl/usr_seq_ctrl_pkg.sv
// ============================================================================
// Module   : usr_seq_ctrl_pkg
// Purpose  : Shared op codes, USR mode codes and FSM encodings for the USR
//            command sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package usr_seq_ctrl_pkg;

  typedef logic [2:0] op_t;
  typedef logic [1:0] mode_t;

  localparam op_t OP_NOP  = 3'b000;
  localparam op_t OP_LOAD = 3'b001;
  localparam op_t OP_SHR  = 3'b010;
  localparam op_t OP_SHL  = 3'b011;
  localparam op_t OP_ROR  = 3'b100;
  localparam op_t OP_ROL  = 3'b101;

  localparam mode_t S_HOLD = 2'b00;
  localparam mode_t S_SHR  = 2'b01;
  localparam mode_t S_SHL  = 2'b10;
  localparam mode_t S_LOAD = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic is_illegal(input op_t op);
    return (op > OP_ROL);
  endfunction

  function automatic logic is_shift_op(input op_t op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
  endfunction

  // Right-moving ops share mode 01; left-moving ops share mode 10.
  function automatic logic is_right_op(input op_t op);
    return (op == OP_SHR) || (op == OP_ROR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/usr_step_cnt.sv
// ============================================================================
// Module   : usr_step_cnt
// Purpose  : Step down-counter with parallel load and last-step flag.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module usr_step_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign last = (r_count == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/usr_seq_ctrl.sv
// ============================================================================
// Module   : usr_seq_ctrl
// Purpose  : Command sequencer driving a universal shift register's mode,
//            parallel data and serial inputs, one command per handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module usr_seq_ctrl
  import usr_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] usr_q,
  output logic [1:0]       usr_s,
  output logic [WIDTH-1:0] usr_x,
  output logic             usr_lsi,
  output logic             usr_rsi,
  output logic             busy,
  output logic             done,
  output logic             err
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  op_t              r_op;
  logic [WIDTH-1:0] r_data;
  logic             r_fill;
  logic             w_accept;
  logic             w_last;
  logic             w_in_shift;
  logic             w_q_unused;

  assign w_accept   = cmd_valid && (r_state == ST_IDLE);
  assign w_in_shift = (r_state == ST_SHIFT);

  // Only the end bits of usr_q feed the rotate path.
  assign w_q_unused = ^usr_q[WIDTH-2:1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (cmd_op == OP_LOAD) begin
            w_state_nxt = ST_LOAD;
          end else if (is_shift_op(cmd_op) && (cmd_cnt != '0)) begin
            w_state_nxt = ST_SHIFT;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_LOAD:  w_state_nxt = ST_DONE;
      ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op   <= OP_NOP;
      r_data <= '0;
      r_fill <= 1'b0;
    end else if (w_accept) begin
      r_op   <= cmd_op;
      r_data <= cmd_data;
      r_fill <= cmd_fill;
    end
  end

  usr_step_cnt #(
    .CNT_W (CNT_W)
  ) u_step_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (w_accept),
    .load_val (cmd_cnt),
    .dec      (w_in_shift),
    .last     (w_last)
  );

  // Everything below decodes from state and latched fields, never from cmd_*.
  always_comb begin
    usr_s = S_HOLD;
    if (r_state == ST_LOAD) begin
      usr_s = S_LOAD;
    end else if (w_in_shift) begin
      usr_s = is_right_op(r_op) ? S_SHR : S_SHL;
    end
  end

  always_comb begin
    usr_rsi = 1'b0;
    usr_lsi = 1'b0;
    if (w_in_shift) begin
      case (r_op)
        OP_SHR:  usr_rsi = r_fill;
        OP_ROR:  usr_rsi = usr_q[0];
        OP_SHL:  usr_lsi = r_fill;
        OP_ROL:  usr_lsi = usr_q[WIDTH-1];
        default: begin
          usr_rsi = 1'b0;
          usr_lsi = 1'b0;
        end
      endcase
    end
  end

  assign usr_x     = (r_state == ST_LOAD) ? r_data : '0;
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign done      = (r_state == ST_DONE);
  assign err       = done && is_illegal(r_op);

endmodule

`default_nettype wire

// File: tb/tb_usr_seq_ctrl.sv
// ============================================================================
// Module   : tb_usr_seq_ctrl
// Purpose  : Self-checking bench: sequencer driving a behavioural 4-bit USR,
//            with a command scoreboard checked at every done pulse.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_usr_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             resetn;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_fill;
  logic [WIDTH-1:0] usr_q_m = '0;
  logic [1:0]       usr_s;
  logic [WIDTH-1:0] usr_x;
  logic             usr_lsi;
  logic             usr_rsi;
  logic             busy;
  logic             done;
  logic             err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int act_cnt = 0;

  typedef struct {
    logic [3:0] q;
    logic       err;
    int         lat;
    int         act;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] ref_q = '0;

  usr_seq_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_data  (cmd_data),
    .cmd_fill  (cmd_fill),
    .usr_q     (usr_q_m),
    .usr_s     (usr_s),
    .usr_x     (usr_x),
    .usr_lsi   (usr_lsi),
    .usr_rsi   (usr_rsi),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural USR, no reset: q[0] receives lsi, q[3] receives rsi.
  always @(posedge clk) begin
    case (usr_s)
      2'b01:   usr_q_m <= {usr_rsi, usr_q_m[3:1]};
      2'b10:   usr_q_m <= {usr_q_m[2:0], usr_lsi};
      2'b11:   usr_q_m <= usr_x;
      default: usr_q_m <= usr_q_m;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mdl(input logic [3:0] q0, input logic [2:0] op,
                               input logic [2:0] cnt, input logic [3:0] d,
                               input logic f, input int now);
    exp_t e;
    logic [3:0] q;
    q = q0;
    e.err = (op == 3'b110) || (op == 3'b111);
    e.lat = 1;
    e.act = 0;
    case (op)
      3'b001: begin q = d; e.lat = 2; e.act = 1; end
      3'b010, 3'b011, 3'b100, 3'b101: begin
        for (int i = 0; i < int'(cnt); i++) begin
          case (op)
            3'b010:  q = {f, q[3:1]};
            3'b011:  q = {q[2:0], f};
            3'b100:  q = {q[0], q[3:1]};
            default: q = {q[2:0], q[3]};
          endcase
        end
        if (cnt != 3'd0) begin
          e.lat = int'(cnt) + 1;
          e.act = int'(cnt);
        end
      end
      default: q = q0;
    endcase
    e.q   = q;
    e.acc = now;
    return e;
  endfunction

  // Monitor: handshake/busy per cycle, scoreboard pop on done, push on accept.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      exp_t e;
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, sb.size() == 0});
      chk("busy", {31'd0, busy}, {31'd0, sb.size() != 0});
      if (usr_s != 2'b00) act_cnt++;
      if (done) begin
        chk("done_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("final_q", {28'd0, usr_q_m}, {28'd0, e.q});
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("latency", cyc - e.acc, e.lat);
          chk("active_cycles", act_cnt, e.act);
        end
      end else if (err) begin
        chk("err_without_done", {31'd0, err}, 32'd0);
      end
      if (cmd_valid && cmd_ready) begin
        e = mdl(ref_q, cmd_op, cmd_cnt, cmd_data, cmd_fill, cyc);
        ref_q = e.q;
        sb.push_back(e);
        act_cnt = 0;
      end
    end
  end

  // Presents one command and returns 2 time units after the accepting edge;
  // cmd_valid stays high so a following send is back-to-back.
  task automatic send(input logic [2:0] op, input logic [2:0] cnt,
                      input logic [3:0] d, input logic f);
    logic got;
    got = 1'b0;
    cmd_op = op; cmd_cnt = cnt; cmd_data = d; cmd_fill = f;
    cmd_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("accept_timeout", {31'd0, got}, 32'd1);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    logic ok;
    ok = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_cnt = 3'($urandom);
    cmd_data = 4'($urandom); cmd_fill = 1'($urandom);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] save_q;
    logic [3:0] frozen_q;
    resetn = 1'b0; cmd_valid = 1'b0;
    cmd_op = '0; cmd_cnt = '0; cmd_data = '0; cmd_fill = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_usr_s", {30'd0, usr_s}, 32'd0);
    chk("rst_usr_x", {28'd0, usr_x}, 32'd0);
    chk("rst_serial", {30'd0, usr_lsi, usr_rsi}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #2;

    send(3'b001, 3'd0, 4'b1010, 1'b0); idle();
    chk("load_1010", {28'd0, usr_q_m}, 32'hA);
    send(3'b010, 3'd2, 4'b0000, 1'b1); idle();
    chk("shr2_fill1", {28'd0, usr_q_m}, 32'hE);
    send(3'b001, 3'd0, 4'b1001, 1'b0); idle();
    send(3'b101, 3'd3, 4'b0000, 1'b0); idle();
    chk("rol3", {28'd0, usr_q_m}, 32'hC);
    send(3'b100, 3'd4, 4'b0000, 1'b0); idle();
    chk("ror4_restore", {28'd0, usr_q_m}, 32'hC);
    send(3'b011, 3'd0, 4'b1111, 1'b1); idle();
    chk("shl0_noop", {28'd0, usr_q_m}, 32'hC);
    send(3'b110, 3'd5, 4'b1111, 1'b1); idle();
    chk("illegal_noop", {28'd0, usr_q_m}, 32'hC);
    send(3'b111, 3'd7, 4'b0000, 1'b0);
    send(3'b000, 3'd3, 4'b0000, 1'b0);
    send(3'b011, 3'd7, 4'b0000, 1'b1); idle();

    // Back-to-back: cmd_valid never drops between commands.
    send(3'b001, 3'd0, 4'b0110, 1'b0);
    send(3'b010, 3'd1, 4'b0000, 1'b0);
    send(3'b101, 3'd1, 4'b0000, 1'b0);
    for (int i = 0; i < 12; i++) begin
      send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           4'($urandom), 1'($urandom));
    end
    idle();

    // Reset in the middle of a long shift: outputs idle at once, q frozen.
    send(3'b001, 3'd0, 4'b1101, 1'b0); idle();
    save_q = ref_q;
    send(3'b010, 3'd7, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    cmd_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_usr_s", {30'd0, usr_s}, 32'd0);
    sb.delete();
    frozen_q = {2'b00, save_q[3:2]};
    repeat (3) @(posedge clk);
    #2;
    chk("midrst_q_frozen", {28'd0, usr_q_m}, {28'd0, frozen_q});
    ref_q = frozen_q;
    resetn = 1'b1;
    @(posedge clk); #2;
    send(3'b100, 3'd1, 4'b0000, 1'b0); idle();
    send(3'b001, 3'd0, 4'b0101, 1'b0); idle();
    chk("post_rst_load", {28'd0, usr_q_m}, 32'h5);
    chk("sb_empty_end", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
